// File: rtl/ps2_game_input_if.sv
// Byte-stream input and game-control outputs between the PS/2 receiver,
// ps2_game_input and vga_controller.
interface ps2_game_input_if;
    logic [7:0] ps2_byte;
    logic       ps2_valid;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic       pause;

    modport master (
        output ps2_byte, ps2_valid,
        input  move_left, move_right, fire, pause
    );

    modport slave (
        input  ps2_byte, ps2_valid,
        output move_left, move_right, fire, pause
    );
endinterface

// File: rtl/ps2_game_input.sv
// PS/2 set-2 scan-code decoder producing movement levels, a rate-limited fire
// pulse and a pause toggle for the game, all registered in the iVGA_CLK domain.
module ps2_game_input #(
    parameter int unsigned FIRE_COOLDOWN = 2500000,
    parameter int unsigned SEQ_TIMEOUT   = 250000,
    parameter logic [7:0]  KEY_LEFT      = 8'h6B,
    parameter logic [7:0]  KEY_RIGHT     = 8'h74,
    parameter logic [7:0]  KEY_FIRE      = 8'h29,
    parameter logic [7:0]  KEY_PAUSE     = 8'h4D
) (
    input  logic            iVGA_CLK,
    input  logic            iRST_n,
    ps2_game_input_if.slave bus
);
    localparam int CD_W = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam int TO_W = $clog2(SEQ_TIMEOUT + 1);
    localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(FIRE_COOLDOWN - 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(SEQ_TIMEOUT);
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t          state_q, state_d, state_cur;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
    logic            l_held_q, l_held_d, r_held_q, r_held_d;
    logic            f_held_q, f_held_d, p_held_q, p_held_d;
    logic            pause_q, pause_d, fire_q, fire_d;
    logic            move_left_q, move_left_d, move_right_q, move_right_d;
    logic            is_make, is_brk, is_ext;
    logic            key_left, key_right, key_fire, key_pause;

    always_comb begin
        // An expired prefix is treated as IDLE in the same cycle, so a byte
        // landing exactly on expiry decodes as a fresh byte.
        state_cur = ((state_q != S_IDLE) && (to_cnt_q == TO_LIMIT)) ? S_IDLE : state_q;
        state_d   = state_cur;
        to_cnt_d  = (state_cur == S_IDLE) ? '0 : to_cnt_q + TO_W'(1);
        is_make   = 1'b0;
        is_brk    = 1'b0;
        is_ext    = 1'b0;
        if (bus.ps2_valid) begin
            to_cnt_d = '0;
            case (state_cur)
                S_IDLE: begin
                    if (bus.ps2_byte == BYTE_EXT)      state_d = S_EXT;
                    else if (bus.ps2_byte == BYTE_BRK) state_d = S_BRK;
                    else                               is_make = 1'b1;
                end
                S_EXT: begin
                    if (bus.ps2_byte == BYTE_BRK) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        is_make = 1'b1;
                        is_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    is_brk  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    is_brk  = 1'b1;
                    is_ext  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end

        key_left  = (bus.ps2_byte == KEY_LEFT);
        key_right = (bus.ps2_byte == KEY_RIGHT);
        key_fire  = (bus.ps2_byte == KEY_FIRE)  && !is_ext;
        key_pause = (bus.ps2_byte == KEY_PAUSE) && !is_ext;

        l_held_d = ((is_make || is_brk) && key_left)  ? is_make : l_held_q;
        r_held_d = ((is_make || is_brk) && key_right) ? is_make : r_held_q;
        f_held_d = ((is_make || is_brk) && key_fire)  ? is_make : f_held_q;
        p_held_d = ((is_make || is_brk) && key_pause) ? is_make : p_held_q;

        // Presses during cooldown or pause are simply lost.
        fire_d   = is_make && key_fire && !f_held_q && (cd_cnt_q == '0) && !pause_q;
        cd_cnt_d = fire_d ? CD_LOAD : ((cd_cnt_q != '0) ? cd_cnt_q - CD_W'(1) : '0);
        pause_d  = pause_q ^ (is_make && key_pause && !p_held_q);

        move_left_d  = l_held_d & ~pause_d;
        move_right_d = r_held_d & ~pause_d;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= S_IDLE;
            to_cnt_q     <= '0;
            cd_cnt_q     <= '0;
            l_held_q     <= 1'b0;
            r_held_q     <= 1'b0;
            f_held_q     <= 1'b0;
            p_held_q     <= 1'b0;
            pause_q      <= 1'b0;
            fire_q       <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            cd_cnt_q     <= cd_cnt_d;
            l_held_q     <= l_held_d;
            r_held_q     <= r_held_d;
            f_held_q     <= f_held_d;
            p_held_q     <= p_held_d;
            pause_q      <= pause_d;
            fire_q       <= fire_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
        end
    end

    assign bus.move_left  = move_left_q;
    assign bus.move_right = move_right_q;
    assign bus.fire       = fire_q;
    assign bus.pause      = pause_q;
endmodule

// File: tb/tb_ps2_game_input.sv
// Bench for ps2_game_input: directed scenarios plus random byte streams,
// compared every cycle against a prefix/timestamp model of the decoder.
module tb_ps2_game_input;
    localparam int C = 200;
    localparam int T = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ps2_game_input_if bus();

    ps2_game_input #(
        .FIRE_COOLDOWN(C),
        .SEQ_TIMEOUT(T),
        .KEY_LEFT(8'h6B),
        .KEY_RIGHT(8'h74),
        .KEY_FIRE(8'h29),
        .KEY_PAUSE(8'h4D)
    ) dut (
        .iVGA_CLK(clk),
        .iRST_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_fire = 0;
    bit armed = 0;

    // Model state: pending prefix (0 none, 1 E0, 2 F0, 3 E0 F0), timestamps.
    longint mc = 0;
    int     pending = 0;
    longint last_strobe = 0;
    longint last_fire = -1000000;
    bit     lh = 0, rh = 0, fh = 0, ph = 0, paused = 0;
    bit     exp_fire = 0, exp_ml = 0, exp_mr = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_key(input bit make, input logic [7:0] b, input bit ext);
        if (b == 8'h6B) lh = make;
        if (b == 8'h74) rh = make;
        if (!ext && b == 8'h29) begin
            if (make && !fh && !paused && (mc - last_fire >= C)) begin
                exp_fire  = 1;
                last_fire = mc;
            end
            fh = make;
        end
        if (!ext && b == 8'h4D) begin
            if (make && !ph) paused = !paused;
            ph = make;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pending = 0; lh = 0; rh = 0; fh = 0; ph = 0; paused = 0;
                last_fire = -1000000; exp_fire = 0;
            end else begin
                logic [7:0] b;
                exp_fire = 0;
                if (bus.ps2_valid) begin
                    b = bus.ps2_byte;
                    if (pending != 0 && (mc - last_strobe > T)) pending = 0;
                    last_strobe = mc;
                    case (pending)
                        0: if (b == 8'hE0) pending = 1;
                           else if (b == 8'hF0) pending = 2;
                           else model_key(1, b, 0);
                        1: if (b == 8'hF0) pending = 3;
                           else begin model_key(1, b, 1); pending = 0; end
                        2: begin model_key(0, b, 0); pending = 0; end
                        default: begin model_key(0, b, 1); pending = 0; end
                    endcase
                end
            end
            exp_ml = lh & !paused;
            exp_mr = rh & !paused;
            if (clk) begin
                mc++;
                armed = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                if (bus.fire) n_fire++;
                check("fire",       int'(bus.fire),       int'(exp_fire));
                check("move_left",  int'(bus.move_left),  int'(exp_ml));
                check("move_right", int'(bus.move_right), int'(exp_mr));
                check("pause",      int'(bus.pause),      int'(paused));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.ps2_byte  = b;
        bus.ps2_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.ps2_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    initial begin
        int base;
        bus.ps2_byte  = 8'h00;
        bus.ps2_valid = 1'b0;
        @(posedge clk); #1;
        idle(2);
        check("reset_move_left", int'(bus.move_left), 0);
        check("reset_pause",     int'(bus.pause),     0);
        rst_n = 1'b1;
        idle(2);

        send(8'hE0); send(8'h6B);
        check("ext_left_make", int'(bus.move_left), 1);
        send(8'hE0); send(8'hF0); send(8'h6B);
        check("ext_left_break", int'(bus.move_left), 0);

        base = n_fire;
        send(8'h29); idle(1000 - 1); send(8'h29); idle(999); send(8'h29);
        send(8'hF0); send(8'h29); idle(C + 5); send(8'h29); idle(2);
        check("typematic_pulses", n_fire - base, 2);
        send(8'hF0); send(8'h29); idle(C + 5);

        base = n_fire;
        send(8'h29); send(8'hF0); send(8'h29); idle(C - 4); send(8'h29);
        send(8'hF0); send(8'h29); idle(2);
        check("cooldown_drop", n_fire - base, 1);
        idle(C + 5);
        base = n_fire;
        send(8'h29); send(8'hF0); send(8'h29); idle(C - 3); send(8'h29); idle(2);
        check("cooldown_edge", n_fire - base, 2);
        send(8'hF0); send(8'h29);

        send(8'h4D);
        check("pause_on", int'(bus.pause), 1);
        send(8'h4D);
        check("pause_repeat", int'(bus.pause), 1);
        send(8'h74);
        check("paused_right", int'(bus.move_right), 0);
        send(8'hF0); send(8'h4D); send(8'h4D);
        check("pause_off", int'(bus.pause), 0);
        check("resume_right", int'(bus.move_right), 1);
        send(8'hF0); send(8'h74);
        check("right_release", int'(bus.move_right), 0);

        send(8'hF0); idle(T + 1); send(8'h74);
        check("timeout_make", int'(bus.move_right), 1);
        send(8'hF0); idle(T - 1); send(8'h74);
        check("before_timeout_break", int'(bus.move_right), 0);
        send(8'h74); send(8'hF0); idle(T); send(8'h74);
        check("timeout_edge_make", int'(bus.move_right), 1);

        send(8'hE0);
        rst_n = 1'b0;
        #1;
        check("rst_async_right", int'(bus.move_right), 0);
        idle(3);
        check("rst_left",  int'(bus.move_left),  0);
        check("rst_right", int'(bus.move_right), 0);
        check("rst_fire",  int'(bus.fire),       0);
        check("rst_pause", int'(bus.pause),      0);
        idle(1); rst_n = 1'b1; idle(1);
        send(8'h6B);
        check("post_rst_left", int'(bus.move_left), 1);
        send(8'hF0); send(8'h6B);

        for (int i = 0; i < 2000; i++) begin
            int r, r2;
            logic [7:0] b;
            r = $urandom_range(0, 15);
            case (r)
                0, 1, 2:  b = 8'hE0;
                3, 4, 5:  b = 8'hF0;
                6, 7:     b = 8'h6B;
                8, 9:     b = 8'h74;
                10, 11:   b = 8'h29;
                12:       b = 8'h4D;
                13:       b = 8'hAA;
                default:  b = 8'($urandom_range(0, 255));
            endcase
            send(b);
            r2 = $urandom_range(0, 99);
            if (r2 < 60)      idle(0);
            else if (r2 < 90) idle($urandom_range(1, 3));
            else if (r2 < 95) idle($urandom_range(T - 2, T + 2));
            else if (r2 < 98) idle($urandom_range(C - 3, C + 2));
            else begin
                rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(1);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
